// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: issues in-order imem requests, tags each return with
// its PC, buffers {pc, instr} for decode, and handles redirects and misaligned faults.
module fetch_sequencer #(
    parameter int unsigned size  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic [size-1:0] pc,
    output logic [size-1:0] pc_next,
    output logic            imem_req,
    output logic [size-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [size-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [size-1:0] redirect_target,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [size-1:0] if_instr,
    output logic [size-1:0] if_pc,
    output logic            fetch_fault
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = CW + 2;

    typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_t;

    state_t          state_q;
    state_t          state_d;

    logic [size-1:0] tag_mem  [DEPTH];
    logic [size-1:0] dpc_mem  [DEPTH];
    logic [size-1:0] dins_mem [DEPTH];

    logic [CW-1:0]   tag_wr_q;
    logic [CW-1:0]   tag_rd_q;
    logic [CW-1:0]   dat_wr_q;
    logic [CW-1:0]   dat_rd_q;
    logic [CW-1:0]   live_q;
    logic [CW-1:0]   discard_q;
    logic [CW-1:0]   dat_count;
    logic [OW-1:0]   occupancy;
    logic [CW:0]     pending;

    logic            run;
    logic            flush;
    logic            redirect_ok;
    logic            redirect_bad;
    logic            grant;
    logic            rsp_drop;
    logic            rsp_take;
    logic            pop;

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and control decode; anything outside RUN keeps the pipeline flushed
    always_comb begin
        state_d      = state_q;
        run          = 1'b0;
        flush        = 1'b1;
        redirect_ok  = 1'b0;
        redirect_bad = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                run          = 1'b1;
                flush        = redirect_valid;
                redirect_ok  = redirect_valid & (redirect_target[1:0] == 2'b00);
                redirect_bad = redirect_valid & (redirect_target[1:0] != 2'b00);
                if (redirect_bad) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign dat_count = dat_wr_q - dat_rd_q;
    // Credit rule: every slot is either buffered, live, or owed to a stale response
    assign occupancy = OW'(live_q) + OW'(discard_q) + OW'(dat_count);
    assign pending   = (CW + 1)'(live_q) + (CW + 1)'(discard_q);

    assign imem_req    = run & ~redirect_valid & (occupancy < OW'(DEPTH));
    assign imem_addr   = pc;
    assign grant       = imem_req & imem_gnt;
    assign rsp_drop    = imem_rvalid & (discard_q != '0);
    assign rsp_take    = imem_rvalid & (discard_q == '0) & (live_q != '0);

    assign if_valid    = run & ~redirect_valid & (dat_count != '0);
    assign pop         = if_valid & if_ready;
    assign if_instr    = dins_mem[dat_rd_q[AW-1:0]];
    assign if_pc       = dpc_mem[dat_rd_q[AW-1:0]];
    assign fetch_fault = (state_q == FAULT);

    // Next PC back to the PC register
    always_comb begin
        pc_next = pc;
        if (redirect_ok) begin
            pc_next = redirect_target;
        end else if (grant) begin
            pc_next = pc + size'(4);
        end
    end

    // Pointers and counters
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            tag_wr_q  <= '0;
            tag_rd_q  <= '0;
            dat_wr_q  <= '0;
            dat_rd_q  <= '0;
            live_q    <= '0;
            discard_q <= '0;
        end else if (flush) begin
            tag_wr_q <= '0;
            tag_rd_q <= '0;
            dat_wr_q <= '0;
            dat_rd_q <= '0;
            live_q   <= '0;
            // Live requests become stale; a response arriving now retires one of them
            if (redirect_ok) begin
                if (imem_rvalid && (pending != '0)) begin
                    discard_q <= CW'(pending - (CW + 1)'(1));
                end else begin
                    discard_q <= CW'(pending);
                end
            end else begin
                discard_q <= '0;
            end
        end else begin
            if (grant) begin
                tag_wr_q <= tag_wr_q + CW'(1);
            end
            if (rsp_take) begin
                tag_rd_q <= tag_rd_q + CW'(1);
                dat_wr_q <= dat_wr_q + CW'(1);
            end
            if (pop) begin
                dat_rd_q <= dat_rd_q + CW'(1);
            end
            if (rsp_drop) begin
                discard_q <= discard_q - CW'(1);
            end
            live_q <= live_q + CW'(grant) - CW'(rsp_take);
        end
    end

    // FIFO storage
    always_ff @(posedge CLK) begin
        if (grant) begin
            tag_mem[tag_wr_q[AW-1:0]] <= pc;
        end
        if (rsp_take && !flush) begin
            dpc_mem[dat_wr_q[AW-1:0]]  <= tag_mem[tag_rd_q[AW-1:0]];
            dins_mem[dat_wr_q[AW-1:0]] <= imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed and randomised-stall bench for fetch_sequencer with a PC register,
// an in-order instruction memory model and a decode-side scoreboard.
module tb_fetch_sequencer;
    logic        CLK;
    logic        RESET_N;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_fault;

    int          checks = 0;
    int          errors = 0;

    fetch_sequencer #(.size(32), .DEPTH(4)) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .pc             (pc),
        .pc_next        (pc_next),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_fault    (fetch_fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // PC register closing the loop
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) pc <= 32'h0;
        else          pc <= pc_next;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory model: responses in order, at least rv_lat cycles after the grant
    int unsigned cyc = 0;
    int          rv_lat = 1;
    int          rv_prob = 100;
    int          grants = 0;
    logic [31:0] q_addr[$];
    int unsigned q_cyc[$];
    logic        rsp_issued = 1'b0;

    always @(negedge CLK) begin
        cyc++;
        if (!RESET_N) begin
            q_addr.delete();
            q_cyc.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            rsp_issued  = 1'b0;
        end else begin
            if (q_addr.size() > 0 && cyc >= q_cyc[0] + rv_lat &&
                $urandom_range(0, 99) < rv_prob) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(q_addr[0]);
                rsp_issued  = 1'b1;
                void'(q_addr.pop_front());
                void'(q_cyc.pop_front());
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
                rsp_issued  = 1'b0;
            end
            #1;
            if (imem_req && imem_gnt) begin
                q_addr.push_back(imem_addr);
                q_cyc.push_back(cyc);
                grants++;
            end
        end
    end

    // Protocol: rvalid only ever answers an outstanding request
    always @(posedge CLK) begin
        if (RESET_N && imem_rvalid)
            assert (rsp_issued) else $error("FAIL protocol: rvalid without request");
    end

    task automatic do_reset();
        @(negedge CLK);
        RESET_N = 1'b0;
        imem_gnt = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        rv_lat = 1;
        rv_prob = 100;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        imem_gnt = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        @(negedge CLK); #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
        checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL reset_pc_next: got %h want 0", pc_next); end
    endtask

    task automatic test_stream();
        int n = 0;
        logic found = 1'b0;
        do_reset();
        imem_gnt = 1'b1;
        if_ready = 1'b1;
        for (int i = 1; i <= 10 && !found; i++) begin
            @(negedge CLK); #2;
            if (if_valid) begin found = 1'b1; n = i; end
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL first_valid_cycle: got %0d want 3", n); end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(negedge CLK); #2; end
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_instr !== mem_word(32'(4 * k))) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b pc=%h ins=%h want pc=%h", k, if_valid, if_pc, if_instr, 32'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        logic hold_bad = 1'b0;
        do_reset();
        imem_gnt = 1'b1;
        if_ready = 1'b0;
        grants = 0;
        repeat (10) begin
            @(negedge CLK); #2;
            if (if_valid && (if_pc !== 32'h0 || if_instr !== mem_word(32'h0))) hold_bad = 1'b1;
        end
        checks++; if (grants !== 4) begin errors++; $display("FAIL bp_grants: got %0d want 4", grants); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b want 0", imem_req); end
        checks++; if (pc !== 32'h10) begin errors++; $display("FAIL bp_pc: got %h want 10", pc); end
        checks++; if (hold_bad !== 1'b0) begin errors++; $display("FAIL bp_hold: got unstable output want stable"); end
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0) begin
            errors++; $display("FAIL bp_head: got v=%b pc=%h want v=1 pc=0", if_valid, if_pc);
        end
        if_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK); #2;
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * k) || if_instr !== mem_word(32'(4 * k))) begin
                errors++;
                $display("FAIL bp_drain_%0d: got v=%b pc=%h ins=%h want pc=%h", k, if_valid, if_pc, if_instr, 32'(4 * k));
            end
        end
    endtask

    // Waits a bounded time for the next valid word and checks its pc/instr
    task automatic expect_next(input string name, input logic [31:0] want);
        logic found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK); #2;
            if (if_valid) found = 1'b1;
        end
        checks++;
        if (!found || if_pc !== want || if_instr !== mem_word(want)) begin
            errors++;
            $display("FAIL %s: got v=%b pc=%h ins=%h want pc=%h ins=%h", name, found, if_pc, if_instr, want, mem_word(want));
        end
    endtask

    task automatic test_redirect_latency();
        do_reset();
        rv_lat = 3;
        imem_gnt = 1'b1;
        if_ready = 1'b1;
        repeat (2) begin @(negedge CLK); #2; end
        @(negedge CLK);
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        #2;
        checks++; if (pc_next !== 32'h100) begin errors++; $display("FAIL rd_pc_next: got %h want 100", pc_next); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_req: got %b want 0", imem_req); end
        @(negedge CLK);
        redirect_valid = 1'b0;
        expect_next("rd_first", 32'h100);
        expect_next("rd_second", 32'h104);
    endtask

    task automatic test_redirect_collide();
        do_reset();
        imem_gnt = 1'b1;
        if_ready = 1'b1;
        repeat (6) @(negedge CLK);
        @(negedge CLK);
        redirect_valid = 1'b1;
        redirect_target = 32'h200;
        #2;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL col_valid: got %b want 0", if_valid); end
        checks++; if (pc_next !== 32'h200) begin errors++; $display("FAIL col_pc_next: got %h want 200", pc_next); end
        @(negedge CLK);
        redirect_valid = 1'b0;
        #2;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL col_stale: got %b want 0", if_valid); end
        expect_next("col_first", 32'h200);
        expect_next("col_second", 32'h204);
    endtask

    task automatic test_wrap();
        do_reset();
        imem_gnt = 1'b1;
        if_ready = 1'b1;
        repeat (3) @(negedge CLK);
        @(negedge CLK);
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFF8;
        @(negedge CLK);
        redirect_valid = 1'b0;
        expect_next("wrap_0", 32'hFFFF_FFF8);
        expect_next("wrap_1", 32'hFFFF_FFFC);
        expect_next("wrap_2", 32'h0000_0000);
        expect_next("wrap_3", 32'h0000_0004);
    endtask

    task automatic test_fault();
        logic [31:0] held;
        do_reset();
        imem_gnt = 1'b1;
        if_ready = 1'b1;
        repeat (5) @(negedge CLK);
        @(negedge CLK);
        redirect_valid = 1'b1;
        redirect_target = 32'h102;
        #2;
        held = pc;
        checks++; if (pc_next !== held) begin errors++; $display("FAIL flt_pc_next: got %h want %h", pc_next, held); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL flt_req: got %b want 0", imem_req); end
        @(negedge CLK);
        redirect_valid = 1'b0;
        #2;
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL flt_flag: got %b want 1", fetch_fault); end
        repeat (5) begin
            @(negedge CLK); #2;
            checks++;
            if (imem_req !== 1'b0 || if_valid !== 1'b0 || pc !== held || fetch_fault !== 1'b1) begin
                errors++;
                $display("FAIL flt_hold: got req=%b v=%b pc=%h f=%b want 0 0 %h 1", imem_req, if_valid, pc, fetch_fault, held);
            end
        end
        @(negedge CLK);
        RESET_N = 1'b0;
        #2;
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL flt_clear: got %b want 0", fetch_fault); end
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        expect_next("flt_restart", 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] exp_pc = 32'h0;
        do_reset();
        rv_prob = 60;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            imem_gnt = ($urandom_range(0, 99) < 50);
            if_ready = ($urandom_range(0, 99) < 70);
            if ($urandom_range(0, 99) < 2) begin
                redirect_valid = 1'b1;
                redirect_target = 32'($urandom_range(0, 1023)) << 2;
            end else begin
                redirect_valid = 1'b0;
            end
            #2;
            if (redirect_valid) begin
                checks++;
                if (if_valid !== 1'b0) begin errors++; $display("FAIL rnd_redirect_valid: got %b want 0", if_valid); end
                exp_pc = redirect_target;
            end else if (if_valid && if_ready) begin
                checks++;
                if (if_pc !== exp_pc || if_instr !== mem_word(exp_pc)) begin
                    errors++;
                    $display("FAIL rnd_word: got pc=%h ins=%h want pc=%h ins=%h", if_pc, if_instr, exp_pc, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
            end
            checks++;
            if (imem_addr !== pc) begin errors++; $display("FAIL rnd_addr: got %h want %h", imem_addr, pc); end
        end
        redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_latency();
        test_redirect_collide();
        test_wrap();
        test_fault();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
